// File: rtl/utm_pkg.sv
// Shared definitions for the universal Turing machine: field widths, special
// symbol/state codes, head-move encodings and the tape controller FSM states.
package utm_pkg;

    localparam int SYM_W   = 3;
    localparam int STATE_W = 3;

    localparam logic [SYM_W-1:0]   BLANK_SYM  = '0;
    localparam logic [STATE_W-1:0] HALT_STATE = 3'd7;

    localparam logic [1:0] DIR_STAY  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_STAY2 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HALT   = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/utm_tape_mem.sv
// Tape storage: TAPE_LEN x SYM_W register file with synchronous clear,
// one write port and two asynchronous read ports (head and peek).
module utm_tape_mem
    import utm_pkg::*;
#(
    parameter int TAPE_LEN = 16,
    parameter int AW       = $clog2(TAPE_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [SYM_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr_a,
    output logic [SYM_W-1:0] o_rdata_a,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [SYM_W-1:0] o_rdata_b
);

    logic [SYM_W-1:0] r_cells [TAPE_LEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPE_LEN; i++) begin
                r_cells[i] <= BLANK_SYM;
            end
        end else if (i_we) begin
            r_cells[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_cells[i_raddr_a];
    assign o_rdata_b = r_cells[i_raddr_b];

endmodule

// File: rtl/utm_tape_controller.sv
// Tape side of the UTM: presents {state, symbol under head} to the transition
// block, then commits the returned {next_state, new_sym, dir} one cycle later.
//
// Handshake: req_valid is high for the whole REQ state and tm_state/tm_sym stay
// stable there; the response is taken on the first rising edge where
// req_valid && resp_valid. resp_valid is ignored in every other state.
module utm_tape_controller
    import utm_pkg::*;
#(
    parameter int TAPE_LEN   = 16,
    parameter int START_HEAD = 8,
    parameter int AW         = $clog2(TAPE_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [AW-1:0]      load_addr,
    input  logic [SYM_W-1:0]   load_sym,
    input  logic               start,
    output logic               req_valid,
    output logic [STATE_W-1:0] tm_state,
    output logic [SYM_W-1:0]   tm_sym,
    input  logic               resp_valid,
    input  logic [STATE_W-1:0] next_state,
    input  logic [SYM_W-1:0]   new_sym,
    input  logic [1:0]         dir,
    output logic [SYM_W-1:0]   peek_sym,
    output logic [AW-1:0]      head_pos,
    output logic               running,
    output logic               halted,
    output logic               fault,
    output logic [15:0]        step_count,
    output fsm_state_t         fsm_state
);

    localparam logic [AW-1:0] HEAD_INIT = AW'(START_HEAD);
    localparam logic [AW-1:0] HEAD_LAST = AW'(TAPE_LEN - 1);

    fsm_state_t         r_fsm;
    logic [AW-1:0]      r_head;
    logic [STATE_W-1:0] r_tm_state;
    logic [15:0]        r_step;
    logic               r_fault;
    logic [STATE_W-1:0] r_resp_state;
    logic [SYM_W-1:0]   r_resp_sym;
    logic [1:0]         r_resp_dir;

    logic               w_stopped;
    logic               w_load_we;
    logic               w_commit_we;
    logic               w_we;
    logic [AW-1:0]      w_waddr;
    logic [SYM_W-1:0]   w_wdata;

    // Loader access is only granted while the machine is not stepping.
    assign w_stopped   = (r_fsm == ST_IDLE) || (r_fsm == ST_HALT);
    assign w_load_we   = w_stopped && load_en;
    assign w_commit_we = (r_fsm == ST_COMMIT);
    assign w_we        = w_load_we || w_commit_we;
    assign w_waddr     = w_commit_we ? r_head : load_addr;
    assign w_wdata     = w_commit_we ? r_resp_sym : load_sym;

    utm_tape_mem #(
        .TAPE_LEN (TAPE_LEN),
        .AW       (AW)
    ) u_tape (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (r_head),
        .o_rdata_a (tm_sym),
        .i_raddr_b (load_addr),
        .o_rdata_b (peek_sym)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= ST_IDLE;
            r_head       <= HEAD_INIT;
            r_tm_state   <= '0;
            r_step       <= '0;
            r_fault      <= 1'b0;
            r_resp_state <= '0;
            r_resp_sym   <= '0;
            r_resp_dir   <= DIR_STAY;
        end else begin
            case (r_fsm)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_fsm      <= ST_REQ;
                        r_head     <= HEAD_INIT;
                        r_tm_state <= '0;
                        r_step     <= '0;
                        r_fault    <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (resp_valid) begin
                        r_resp_state <= next_state;
                        r_resp_sym   <= new_sym;
                        r_resp_dir   <= dir;
                        r_fsm        <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_tm_state <= r_resp_state;
                    if (r_step != 16'hFFFF) begin
                        r_step <= r_step + 16'd1;
                    end
                    // Halting takes priority over the move; edge hits stop without wrapping.
                    if (r_resp_state == HALT_STATE) begin
                        r_fsm <= ST_HALT;
                    end else if (r_resp_dir == DIR_LEFT) begin
                        if (r_head == '0) begin
                            r_fault <= 1'b1;
                            r_fsm   <= ST_HALT;
                        end else begin
                            r_head <= r_head - 1'b1;
                            r_fsm  <= ST_REQ;
                        end
                    end else if (r_resp_dir == DIR_RIGHT) begin
                        if (r_head == HEAD_LAST) begin
                            r_fault <= 1'b1;
                            r_fsm   <= ST_HALT;
                        end else begin
                            r_head <= r_head + 1'b1;
                            r_fsm  <= ST_REQ;
                        end
                    end else begin
                        r_fsm <= ST_REQ;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign req_valid  = (r_fsm == ST_REQ);
    assign running    = (r_fsm == ST_REQ) || (r_fsm == ST_COMMIT);
    assign halted     = (r_fsm == ST_HALT);
    assign tm_state   = r_tm_state;
    assign head_pos   = r_head;
    assign fault      = r_fault;
    assign step_count = r_step;
    assign fsm_state  = r_fsm;

endmodule

// File: tb/tb_utm_tape_controller.sv
// Bench for utm_tape_controller: a reference model of tape/head/state predicts
// each commit; predictions are queued at the handshake and checked after COMMIT.
module tb_utm_tape_controller;
    import utm_pkg::*;

    localparam int TAPE_LEN = 16;
    localparam int AW       = 4;
    localparam int EXP_W    = 3 + 4 + 16 + 1 + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               load_en;
    logic [AW-1:0]      load_addr;
    logic [SYM_W-1:0]   load_sym;
    logic               start;
    logic               req_valid;
    logic [STATE_W-1:0] tm_state;
    logic [SYM_W-1:0]   tm_sym;
    logic               resp_valid;
    logic [STATE_W-1:0] next_state;
    logic [SYM_W-1:0]   new_sym;
    logic [1:0]         dir;
    logic [SYM_W-1:0]   peek_sym;
    logic [AW-1:0]      head_pos;
    logic               running;
    logic               halted;
    logic               fault;
    logic [15:0]        step_count;
    fsm_state_t         fsm_state;

    utm_tape_controller #(.TAPE_LEN(TAPE_LEN), .START_HEAD(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_sym   (load_sym),
        .start      (start),
        .req_valid  (req_valid),
        .tm_state   (tm_state),
        .tm_sym     (tm_sym),
        .resp_valid (resp_valid),
        .next_state (next_state),
        .new_sym    (new_sym),
        .dir        (dir),
        .peek_sym   (peek_sym),
        .head_pos   (head_pos),
        .running    (running),
        .halted     (halted),
        .fault      (fault),
        .step_count (step_count),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    // Scoreboard and reference model
    logic [EXP_W-1:0] exp_q[$];
    logic [SYM_W-1:0] m_tape [TAPE_LEN];
    int               m_head;
    logic [2:0]       m_state;
    logic [15:0]      m_steps;
    logic             m_halt;
    logic             m_fault;
    int               n_tests = 0;
    int               n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < TAPE_LEN; i++) m_tape[i] = '0;
        m_head = 8; m_state = 0; m_steps = 0; m_halt = 0; m_fault = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic do_load(input int addr, input logic [2:0] sym);
        load_en = 1'b1; load_addr = AW'(addr); load_sym = sym;
        tick();
        load_en = 1'b0;
        m_tape[addr] = sym;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_head = 8; m_state = 0; m_steps = 0; m_fault = 0; m_halt = 0;
    endtask

    task automatic check_tape(input string tag);
        for (int i = 0; i < TAPE_LEN; i++) begin
            load_addr = AW'(i);
            #1;
            check(tag, 32'(peek_sym), 32'(m_tape[i]));
        end
    endtask

    // One full step: wait for REQ, hold off lat cycles, respond, verify the commit.
    task automatic do_step(input logic [2:0] ns, input logic [2:0] sym, input logic [1:0] d,
                           input int lat);
        int budget;
        int old_head;
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] exp_word;
        budget = 0;
        while (!req_valid && budget < 50) begin
            tick();
            budget++;
        end
        check("req_wait", 32'(req_valid), 32'd1);
        check("req_state", 32'(tm_state), 32'(m_state));
        check("req_sym", 32'(tm_sym), 32'(m_tape[m_head]));
        load_addr = AW'(m_head);
        for (int i = 0; i < lat; i++) begin
            tick();
            check("bp_valid", 32'(req_valid), 32'd1);
            check("bp_state", 32'(tm_state), 32'(m_state));
            check("bp_sym", 32'(tm_sym), 32'(m_tape[m_head]));
            check("bp_tape", 32'(peek_sym), 32'(m_tape[m_head]));
            check("bp_steps", 32'(step_count), 32'(m_steps));
        end
        resp_valid = 1'b1; next_state = ns; new_sym = sym; dir = d;
        tick();
        resp_valid = 1'b0;
        check("commit_noreq", 32'(req_valid), 32'd0);
        check("commit_run", 32'(running), 32'd1);
        old_head = m_head;
        m_tape[m_head] = sym;
        m_state = ns;
        if (m_steps != 16'hFFFF) m_steps++;
        if (ns == 3'd7) m_halt = 1;
        else if (d == 2'b01 && m_head == 0) begin m_halt = 1; m_fault = 1; end
        else if (d == 2'b10 && m_head == TAPE_LEN - 1) begin m_halt = 1; m_fault = 1; end
        else if (d == 2'b01) m_head--;
        else if (d == 2'b10) m_head++;
        exp_word = {m_state, 4'(m_head), m_steps, m_halt, m_fault};
        exp_q.push_back(exp_word);
        tick();
        e = exp_q.pop_front();
        check("post_state", 32'(tm_state), 32'(e[24:22]));
        check("post_head", 32'(head_pos), 32'(e[21:18]));
        check("post_steps", 32'(step_count), 32'(e[17:2]));
        check("post_halted", 32'(halted), 32'(e[1]));
        check("post_fault", 32'(fault), 32'(e[0]));
        check("post_req", 32'(req_valid), 32'(!e[1]));
        load_addr = AW'(old_head);
        #1;
        check("post_tape", 32'(peek_sym), 32'(m_tape[old_head]));
    endtask

    initial begin
        rst = 1'b0; load_en = 1'b0; load_addr = '0; load_sym = '0; start = 1'b0;
        resp_valid = 1'b0; next_state = '0; new_sym = '0; dir = '0;
        model_clear();

        // Reset state
        do_reset();
        check_tape("rst_tape");
        check("rst_head", 32'(head_pos), 32'd8);
        check("rst_state", 32'(tm_state), 32'd0);
        check("rst_req", 32'(req_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_steps", 32'(step_count), 32'd0);
        check("rst_fsm", 32'(fsm_state), 32'(ST_IDLE));

        // Single zero-latency step, then backpressure, then a walk ending in halt
        do_load(8, 3'd3);
        do_start();
        do_step(3'd2, 3'd5, 2'b10, 0);
        do_step(3'd4, 3'd6, 2'b10, 5);
        do_step(3'd3, 3'd2, 2'b01, 0);
        do_step(3'd1, 3'd1, 2'b11, 2);
        do_step(3'd5, 3'd4, 2'b01, 0);
        do_step(3'd7, 3'd1, 2'b01, 0);
        check("halt_head", 32'(head_pos), 32'd8);
        check("halt_running", 32'(running), 32'd0);

        // Responses arriving in HALT must be ignored
        resp_valid = 1'b1; next_state = 3'd2; new_sym = 3'd6; dir = 2'b10;
        repeat (3) tick();
        resp_valid = 1'b0;
        check("halt_ign_state", 32'(tm_state), 32'd7);
        check("halt_ign_steps", 32'(step_count), 32'(m_steps));
        check("halt_ign_head", 32'(head_pos), 32'd8);
        check_tape("halt_ign_tape");

        // Load and start together in HALT: the run must see the loaded symbol
        load_en = 1'b1; load_addr = 4'd8; load_sym = 3'd6; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        m_tape[8] = 3'd6; m_head = 8; m_state = 0; m_steps = 0; m_halt = 0; m_fault = 0;
        check("restart_steps", 32'(step_count), 32'd0);

        // Walk to the left edge and step off it
        for (int i = 0; i < 8; i++)
            do_step(3'($urandom_range(0, 6)), 3'($urandom_range(0, 7)), 2'b01,
                    int'($urandom_range(0, 2)));
        check("ledge_head0", 32'(head_pos), 32'd0);
        do_step(3'd3, 3'd7, 2'b01, 1);
        check("ledge_fault", 32'(fault), 32'd1);
        check("ledge_head", 32'(head_pos), 32'd0);
        do_start();
        check("clr_fault", 32'(fault), 32'd0);
        check("clr_head", 32'(head_pos), 32'd8);
        check("clr_state", 32'(tm_state), 32'd0);
        check("clr_steps", 32'(step_count), 32'd0);

        // Walk to the right edge and step off it
        for (int i = 0; i < 7; i++)
            do_step(3'($urandom_range(0, 6)), 3'($urandom_range(0, 7)), 2'b10,
                    int'($urandom_range(0, 3)));
        do_step(3'd2, 3'd5, 2'b10, 0);
        check("redge_fault", 32'(fault), 32'd1);
        check("redge_head", 32'(head_pos), 32'd15);
        check_tape("redge_tape");

        // Load/start while running are ignored
        do_start();
        check("ill_req", 32'(req_valid), 32'd1);
        load_en = 1'b1; load_addr = 4'd3; load_sym = 3'd7; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        check("ill_still_req", 32'(req_valid), 32'd1);
        check("ill_steps", 32'(step_count), 32'd0);
        check_tape("ill_tape");
        do_step(3'd1, 3'd2, 2'b00, 0);
        load_en = 1'b1; load_addr = 4'd8; load_sym = 3'd0;
        resp_valid = 1'b1; next_state = 3'd4; new_sym = 3'd3; dir = 2'b10;
        tick();
        resp_valid = 1'b0;
        load_en = 1'b0;
        check("ill_commit", 32'(fsm_state), 32'(ST_COMMIT));
        tick();
        m_tape[8] = 3'd3; m_head = 9; m_state = 3'd4; m_steps++;
        check_tape("ill_commit_tape");

        // Reset during REQ with a response pending
        check("mid_req", 32'(req_valid), 32'd1);
        resp_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0; resp_valid = 1'b0;
        model_clear();
        check("mrst_fsm", 32'(fsm_state), 32'(ST_IDLE));
        check("mrst_head", 32'(head_pos), 32'd8);
        check("mrst_steps", 32'(step_count), 32'd0);
        check("mrst_state", 32'(tm_state), 32'd0);
        check_tape("mrst_tape");
        tick();
        check("mrst_stay_idle", 32'(running), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
